// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: load/store unit driving a 64-bit byte-addressed data memory.
// Handles byte/half/word/doubleword accesses. Loads are sign- or zero-extended.
// Sub-doubleword stores use read-modify-write because the memory always writes
// all 8 bytes at once.
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned accesses.
// Without it, misaligned accesses go through the base/offset path.

module lsu_dmem_master #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [63:0] mem_adr,
  output logic [63:0] mem_datain,
  output logic        mem_w,
  output logic        mem_r,
  input  logic [63:0] mem_dataout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LD_RD = 3'd1,
    ST_RD = 3'd2,
    ST_WR = 3'd3,
    RESP  = 3'd4
  } state_t;

  // Highest legal 8-byte window base, and the range limit widened to 65 bits
  // so that addr + n can never wrap.
  localparam logic [63:0] MaxBase = 64'(MEM_BYTES - 8);
  localparam logic [64:0] MemEnd  = 65'(MEM_BYTES);

  state_t state, state_next;

  // Request fields latched at acceptance.
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [63:0] base_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;
  logic [63:0] merge_q;
  logic [63:0] rdata_q;
  logic        err_q;

  // Request decode signals.
  logic [3:0]  req_nbytes;
  logic [64:0] req_end;
  logic [63:0] req_base;
  logic [2:0]  req_off;
  logic        req_range_err;
  logic        req_align_err;
  logic        req_err;

  // Datapath signals.
  logic [63:0] ld_shifted;
  logic [63:0] ld_ext;
  logic [7:0]  st_lane_mask;
  logic [7:0]  st_mask;
  logic [63:0] st_shifted;
  logic [63:0] st_merged;

  // Decode the incoming request: access size, 8-byte window base, byte offset
  // inside the window, and the error conditions.
  always_comb begin
    req_nbytes    = 4'd1 << req_size;
    req_end       = {1'b0, req_addr} + {61'd0, req_nbytes};
    req_range_err = req_end > MemEnd;
    req_base      = (req_addr < MaxBase) ? req_addr : MaxBase;
    // The offset is below 8 for every in-range access, so the low three bits
    // of the subtraction are enough.
    req_off       = req_addr[2:0] - req_base[2:0];
`ifdef LSU_ALIGN_CHECK_EN
    req_align_err = (req_addr[2:0] & (req_nbytes[2:0] - 3'd1)) != 3'd0;
`else
    req_align_err = 1'b0;
`endif
    req_err       = req_range_err | req_align_err;
  end

  // Shift the read window so the addressed byte lands in bits [7:0].
  // Then keep n bytes and extend them.
  always_comb begin
    ld_shifted = mem_dataout >> {off_q, 3'b000};
    ld_ext     = ld_shifted;
    case (size_q)
      2'b00: ld_ext = signed_q ? {{56{ld_shifted[7]}}, ld_shifted[7:0]}
                               : {56'd0, ld_shifted[7:0]};
      2'b01: ld_ext = signed_q ? {{48{ld_shifted[15]}}, ld_shifted[15:0]}
                               : {48'd0, ld_shifted[15:0]};
      2'b10: ld_ext = signed_q ? {{32{ld_shifted[31]}}, ld_shifted[31:0]}
                               : {32'd0, ld_shifted[31:0]};
      default: ld_ext = ld_shifted;
    endcase
  end

  // Build the write image: replace bytes offset..offset+n-1 of the value
  // read back with the low n bytes of the store data.
  always_comb begin
    st_lane_mask = 8'h01;
    case (size_q)
      2'b00:   st_lane_mask = 8'h01;
      2'b01:   st_lane_mask = 8'h03;
      2'b10:   st_lane_mask = 8'h0F;
      default: st_lane_mask = 8'hFF;
    endcase
    st_mask    = st_lane_mask << off_q;
    st_shifted = wdata_q << {off_q, 3'b000};
    st_merged  = merge_q;
    for (int i = 0; i < 8; i++) begin
      if (st_mask[i]) begin
        st_merged[8*i +: 8] = st_shifted[8*i +: 8];
      end
    end
    if (size_q == 2'b11) begin
      st_merged = wdata_q;
    end
  end

  // State register. Reset is asynchronous, so a write in flight is dropped
  // immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_next = RESP;
          end else if (!req_we) begin
            state_next = LD_RD;
          end else if (req_size == 2'b11) begin
            state_next = ST_WR;
          end else begin
            state_next = ST_RD;
          end
        end
      end
      LD_RD: state_next = RESP;
      ST_RD: state_next = ST_WR;
      ST_WR: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers.
  // - At acceptance: latch the request and pre-load the response.
  // - LD_RD: capture the extended load result.
  // - ST_RD: capture the read-back data used for the merge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      base_q   <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            base_q   <= req_base;
            off_q    <= req_off;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            err_q    <= req_err;
          end
        end
        LD_RD: rdata_q <= ld_ext;
        ST_RD: merge_q <= mem_dataout;
        default: ;
      endcase
    end
  end

  // Handshake and memory-port outputs, decoded from the current state.
  // Every memory-port output is zero outside the access states.
  always_comb begin
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    mem_adr    = '0;
    mem_datain = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      LD_RD: begin
        mem_r   = 1'b1;
        mem_adr = base_q;
      end
      ST_RD: begin
        mem_r   = 1'b1;
        mem_adr = base_q;
      end
      ST_WR: begin
        mem_w      = 1'b1;
        mem_adr    = base_q;
        mem_datain = st_merged;
      end
      RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // we_q is part of the latched request. Its information is already encoded
  // in the state path, so it only feeds this reduction.
  logic unused_ok;
  assign unused_ok = we_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Testbench for lsu_dmem_master.
// - Memory model: a byte array preloaded with byte i = i.
// - Reference model: a byte-level view of memory that predicts each
//   response, latency and write image.
// - Literal checks: hand-computed values that pin the model.
// Honors LSU_ALIGN_CHECK_EN the same way as the design.

module tb_lsu_dmem_master;

  localparam int MemBytes = 256;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [63:0] mem_adr;
  logic [63:0] mem_datain;
  logic        mem_w;
  logic        mem_r;
  logic [63:0] mem_dataout;

  lsu_dmem_master #(.MEM_BYTES(MemBytes)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_adr(mem_adr), .mem_datain(mem_datain), .mem_w(mem_w), .mem_r(mem_r),
    .mem_dataout(mem_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simulated data memory: combinational read, 8-byte write on the clock edge.
  logic [7:0] dmem    [0:MemBytes-1];
  logic [7:0] ref_mem [0:MemBytes-1];

  always_comb begin
    mem_dataout = '0;
    if (mem_r) begin
      for (int i = 0; i < 8; i++) begin
        mem_dataout[8*i +: 8] = dmem[8'(mem_adr[7:0] + 8'(i))];
      end
    end
  end

  always @(posedge clk) begin
    if (mem_w) begin
      for (int i = 0; i < 8; i++) begin
        dmem[8'(mem_adr[7:0] + 8'(i))] <= mem_datain[8*i +: 8];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard state shared between the stimulus task and the compare process.
  logic        exp_valid = 1'b0;
  logic        txn_active = 1'b0;
  logic        exp_err;
  logic [63:0] exp_rdata;
  logic [63:0] exp_base;
  logic [63:0] exp_img;
  int          exp_lat;
  int          exp_rd;
  int          exp_wr;
  int          rd_count;
  int          wr_count;
  logic [63:0] last_write = '0;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model, working byte by byte on ref_mem.
  // Store images are committed only after the response handshake.
  task automatic modelRequest(input logic we, input logic [1:0] size,
                              input logic sgn, input logic [63:0] addr,
                              input logic [63:0] wdata);
    int n;
    logic [64:0] last_plus_one;
    logic [63:0] val;
    n = 1 << size;
    last_plus_one = {1'b0, addr} + 65'(n);
    exp_err = last_plus_one > 65'(MemBytes);
`ifdef LSU_ALIGN_CHECK_EN
    if ((addr % 64'(n)) != 64'd0) exp_err = 1'b1;
`endif
    exp_rdata = '0;
    exp_base  = '0;
    exp_img   = '0;
    exp_lat   = 1;
    exp_rd    = 0;
    exp_wr    = 0;
    if (!exp_err) begin
      exp_base = (addr < 64'(MemBytes - 8)) ? addr : 64'(MemBytes - 8);
      if (!we) begin
        val = '0;
        for (int i = 0; i < n; i++) val[8*i +: 8] = ref_mem[int'(addr) + i];
        if (sgn && n < 8 && val[8*n-1]) begin
          for (int i = 8*n; i < 64; i++) val[i] = 1'b1;
        end
        exp_rdata = val;
        exp_lat   = 2;
        exp_rd    = 1;
      end else begin
        for (int i = 0; i < 8; i++) exp_img[8*i +: 8] = ref_mem[int'(exp_base) + i];
        for (int i = 0; i < n; i++) begin
          exp_img[8*(int'(addr - exp_base) + i) +: 8] = wdata[8*i +: 8];
        end
        exp_lat = (n == 8) ? 2 : 3;
        exp_rd  = (n == 8) ? 0 : 1;
        exp_wr  = 1;
      end
    end
  endtask

  // Per-cycle compare process.
  // - Always: read and write strobes never overlap.
  // - Idle: no strobes while the unit is idle.
  // - During a transaction: memory address, write image and response
  //   against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("rw_exclusive", {63'd0, mem_r & mem_w}, 64'd0);
      if (req_ready) checkOutput("idle_strobe", {63'd0, mem_r | mem_w}, 64'd0);
      if (exp_valid && mem_r) checkOutput("rd_adr", mem_adr, exp_base);
      if (exp_valid && mem_w) begin
        checkOutput("wr_adr", mem_adr, exp_base);
        checkOutput("wr_data", mem_datain, exp_img);
      end
      if (exp_valid && rsp_valid) begin
        checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
        checkOutput("rsp_err", {63'd0, rsp_err}, {63'd0, exp_err});
      end
      if (mem_w) last_write = mem_datain;
      if (txn_active) begin
        rd_count += int'(mem_r);
        wr_count += int'(mem_w);
      end
    end
  end

  // Issue one request and follow it to its response handshake.
  // Entered and left at a falling edge, so back-to-back calls exercise the
  // one-cycle turnaround.
  task automatic applyStimulus(input string name, input logic we,
                               input logic [1:0] size, input logic sgn,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input int hold, input logic pin,
                               input logic [63:0] pin_val);
    int guard;
    int lat;
    logic seen;
    logic [63:0] held;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    rsp_ready  = (hold == 0);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({name, "_ready"}, {63'd0, req_ready}, 64'd1);
    modelRequest(we, size, sgn, addr, wdata);
    rd_count = 0;
    wr_count = 0;
    @(posedge clk);
    exp_valid  = 1'b1;
    txn_active = 1'b1;
    #1;
    req_valid = 1'b0;
    req_addr  = 64'hDEAD_0000_0000_0000;
    req_wdata = 64'h5555_5555_5555_5555;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) checkOutput({name, "_ready_drop"}, {63'd0, req_ready}, 64'd0);
      seen = rsp_valid;
    end
    checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
    if (pin) checkOutput({name, "_literal"}, rsp_rdata, pin_val);
    held = rsp_rdata;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      checkOutput({name, "_hold_valid"}, {63'd0, rsp_valid}, 64'd1);
      checkOutput({name, "_hold_rdata"}, rsp_rdata, held);
      checkOutput({name, "_hold_ready"}, {63'd0, req_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_valid  = 1'b0;
    txn_active = 1'b0;
    checkOutput({name, "_mem_r_cycles"}, 64'(rd_count), 64'(exp_rd));
    checkOutput({name, "_mem_w_cycles"}, 64'(wr_count), 64'(exp_wr));
    if (we && !exp_err) begin
      for (int i = 0; i < 8; i++) ref_mem[int'(exp_base) + i] = exp_img[8*i +: 8];
    end
    @(negedge clk);
    checkOutput({name, "_rsp_done"}, {63'd0, rsp_valid}, 64'd0);
  endtask

  // Reset values, checked both before and after clock edges while in reset.
  task automatic checkResetValues(input string name);
    checkOutput({name, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    checkOutput({name, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    checkOutput({name, "_rsp_rdata"}, rsp_rdata, 64'd0);
    checkOutput({name, "_rsp_err"}, {63'd0, rsp_err}, 64'd0);
    checkOutput({name, "_mem_rw"}, {62'd0, mem_r, mem_w}, 64'd0);
    checkOutput({name, "_mem_adr"}, mem_adr, 64'd0);
    checkOutput({name, "_mem_datain"}, mem_datain, 64'd0);
  endtask

  // Directed sequence.
  initial begin
    for (int i = 0; i < MemBytes; i++) begin
      dmem[i]    = 8'(i);
      ref_mem[i] = 8'(i);
    end
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;
    #2;
    checkResetValues("reset_early");
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset_late");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("ld_d_10", 1'b0, 2'b11, 1'b0, 64'h10, '0, 0, 1'b1, 64'h1716151413121110);
    applyStimulus("ld_b_80s", 1'b0, 2'b00, 1'b1, 64'h80, '0, 0, 1'b1, 64'hFFFFFFFFFFFFFF80);
    applyStimulus("ld_b_80u", 1'b0, 2'b00, 1'b0, 64'h80, '0, 0, 1'b1, 64'h0000000000000080);
    applyStimulus("ld_b_fe", 1'b0, 2'b00, 1'b0, 64'hFE, '0, 0, 1'b1, 64'hFE);
    applyStimulus("st_h_20", 1'b1, 2'b01, 1'b0, 64'h20, 64'h1234_5678_9ABC_BEEF, 0, 1'b1, 64'd0);
    checkOutput("st_h_20_image", last_write, 64'h272625242322BEEF);
    applyStimulus("ld_d_20", 1'b0, 2'b11, 1'b0, 64'h20, '0, 0, 1'b1, 64'h272625242322BEEF);
    applyStimulus("ld_d_f9", 1'b0, 2'b11, 1'b0, 64'hF9, '0, 0, 1'b1, 64'd0);
    applyStimulus("ld_b_100", 1'b0, 2'b00, 1'b0, 64'h100, '0, 0, 1'b1, 64'd0);
`ifdef LSU_ALIGN_CHECK_EN
    applyStimulus("ld_w_22", 1'b0, 2'b10, 1'b0, 64'h22, '0, 0, 1'b1, 64'd0);
`else
    applyStimulus("ld_w_22", 1'b0, 2'b10, 1'b0, 64'h22, '0, 0, 1'b1, 64'h25242322);
`endif
    applyStimulus("ld_h_fe_s", 1'b0, 2'b01, 1'b1, 64'hFE, '0, 0, 1'b1, 64'hFFFFFFFFFFFFFFFE);
    applyStimulus("ld_w_7c_s", 1'b0, 2'b10, 1'b1, 64'h7C, '0, 0, 1'b1, 64'h7F7E7D7C);
    applyStimulus("st_w_fc", 1'b1, 2'b10, 1'b0, 64'hFC, 64'hDEADBEEF, 0, 1'b0, 64'd0);
    applyStimulus("ld_d_f8", 1'b0, 2'b11, 1'b0, 64'hF8, '0, 0, 1'b1, 64'hDEADBEEFFBFAF9F8);
    applyStimulus("st_d_40", 1'b1, 2'b11, 1'b0, 64'h40, 64'h0123456789ABCDEF, 0, 1'b0, 64'd0);
    applyStimulus("ld_d_40", 1'b0, 2'b11, 1'b0, 64'h40, '0, 0, 1'b1, 64'h0123456789ABCDEF);
    applyStimulus("ld_d_10_bp", 1'b0, 2'b11, 1'b0, 64'h10, '0, 5, 1'b1, 64'h1716151413121110);

    // Byte store interrupted by reset while the write strobe is up.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 64'h30;
    req_wdata  = 64'hAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_st_rd_phase", {62'd0, mem_r, mem_w}, 64'd2);
    @(negedge clk);
    checkOutput("rst_st_wr_phase", {62'd0, mem_r, mem_w}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mem_w_drop", {63'd0, mem_w}, 64'd0);
    checkResetValues("rst_mid");
    @(negedge clk);
    checkOutput("rst_no_write", {56'd0, dmem[8'h30]}, 64'h30);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus("ld_b_30", 1'b0, 2'b00, 1'b0, 64'h30, '0, 0, 1'b1, 64'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Keep the run bounded even if the design stalls somewhere unexpected.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
